key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Reads the board's active-low push buttons, the input-side counterpart of the LED pattern outputs. Each button is synchronised to the 50 MHz system clock, debounced, and turned into a clean level plus single-cycle press, release and long-press events. These events drive the LED and demo control logic in place of free-running timers.

Parameters:
KEY_NUM, 3, number of independent button channels.
DEB_CYCLES, 1000000, stable-sample count required to accept an edge (20 ms at 50 MHz).
LONG_CYCLES, 50000000, held-time count for a long-press event (1 s at 50 MHz); must be greater than DEB_CYCLES.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  asynchronous active-low reset.
key_in  input  KEY_NUM  raw button pins, active-low (0 = pressed), asynchronous to clk.
key_state  output  KEY_NUM  debounced level per channel, 1 = held.
key_press  output  KEY_NUM  one-cycle pulse when a press is accepted.
key_release  output  KEY_NUM  one-cycle pulse when a release is accepted.
key_long  output  KEY_NUM  one-cycle pulse, at most once per hold, after LONG_CYCLES held.

Behaviour:
- Reset (async assert, sync release): synchroniser flops go to 1 (released); every FSM goes to S_IDLE; counters are 0; key_state, key_press, key_release and key_long are all 0.
- Synchroniser: two flops per channel. Downstream logic sees only the signal "sync", which lags the pin by 2 edges.
- Per-channel FSM, with channels fully independent. Counter width is clog2(LONG_CYCLES).
  - S_IDLE: if sync = 0, go to S_PDEB and set deb_cnt = 0.
  - S_PDEB: if sync = 1, return to S_IDLE (bounce rejected, no pulse). Otherwise increment deb_cnt. On the edge where deb_cnt = DEB_CYCLES-1, go to S_HELD, set key_state = 1, pulse key_press, set hold_cnt = 0 and clear long_done.
  - S_HELD: increment hold_cnt, saturating at LONG_CYCLES-1. When hold_cnt = LONG_CYCLES-1 and long_done = 0, pulse key_long and set long_done. If sync = 1, go to S_RDEB and set deb_cnt = 0.
  - S_RDEB: if sync = 0, return to S_HELD; hold_cnt and long_done are preserved, so a release glitch does not restart the long timer. Otherwise increment deb_cnt, and hold_cnt keeps counting. On deb_cnt = DEB_CYCLES-1, go to S_IDLE, set key_state = 0 and pulse key_release.
- Latency: for a clean pin fall at edge 0, key_press is high in the cycle after edge 3+DEB_CYCLES. Release timing is symmetric.
- Pulses are registered and high for exactly one clk cycle. key_long never repeats within one hold. A release never occurs without a preceding press.
- Simultaneous events on different channels are reported in the same cycle on their own bits. No priority encoding is applied.
- Reset mid-hold drops key_state to 0 immediately and emits no release pulse. After reset, a still-held button is re-detected as a fresh press after the full debounce time.
- A pin that toggles faster than DEB_CYCLES produces no events and leaves key_state unchanged.

Decomposition:
- Shared package key_pkg: FSM state encoding (S_IDLE, S_PDEB, S_HELD, S_RDEB, 2-bit), default DEB_CYCLES and LONG_CYCLES constants, and a clog2-based counter-width function.
- Sub-module key_debounce_ch: one channel (synchroniser, FSM, counters, three pulse outputs). The top generates KEY_NUM instances and concatenates their outputs.

Test Plan:
Simulation uses DEB_CYCLES=16 and LONG_CYCLES=64.
1. Clean press: key_in[0] goes 1->0 at edge 0 and stays low -> key_press[0] is high for one cycle after edge 19, key_state[0] = 1 from then, and the other bits stay 0.
2. Bounce: key_in[1] toggles every 5 cycles for 60 cycles, then stays high -> no pulses on any output and key_state[1] = 0 throughout.
3. Long press: key_in[2] is held low for 200 cycles -> key_press[2] once, then exactly one key_long[2] 64 cycles later, with none after. Releasing gives key_release[2] 19 cycles after the pin rises.
4. Release glitch: while held, key_in[0] goes high for 8 cycles and then low again -> no release pulse, key_state[0] stays 1, and key_long timing is unchanged from the uninterrupted case.
5. Simultaneous: all three pins fall on the same edge -> key_press = 3'b111 for one cycle, and later key_release = 3'b111 for one cycle.
6. Reset mid-hold: assert rst_n = 0 while key_state[1] = 1 with the pin still low -> outputs go to 0 asynchronously with no release pulse. After rst_n = 1, key_press[1] fires after edge 19.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer: FSM encoding,
// default timing constants, the per-channel event bundle and a
// counter-width helper.
package key_pkg;

    // 20 ms and 1 s at a 50 MHz system clock.
    localparam int DEB_CYCLES_DEF  = 1000000;
    localparam int LONG_CYCLES_DEF = 50000000;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PDEB = 2'd1;
    localparam logic [1:0] S_HELD = 2'd2;
    localparam logic [1:0] S_RDEB = 2'd3;

    // Everything one channel reports to the outside world.
    typedef struct packed {
        logic level;   // debounced level, 1 = held
        logic press;   // one-cycle press pulse
        logic rel;     // one-cycle release pulse
        logic lng;     // one-cycle long-press pulse
    } key_evt_t;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One push-button channel: two-flop synchroniser, press/release debounce
// FSM, long-press timer and registered single-cycle event pulses.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | button released, waiting for sync to go low
//  S_PDEB | sync low, counting stable samples before accepting a press
//  S_HELD | press accepted, long-press timer running
//  S_RDEB | sync high while held, counting stable samples before release
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     key_in,
    output key_evt_t evt
);

    // Both counters share the width needed by the longer timer.
    localparam int            CW        = cnt_width(LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    logic          sync_meta;
    logic          sync;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] deb_cnt;
    logic [CW-1:0] deb_nxt;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_nxt;
    logic [CW-1:0] hold_inc;
    logic          long_done;
    logic          long_done_nxt;
    logic          level;
    logic          level_nxt;

    logic          press_nxt;
    logic          rel_nxt;
    logic          lng_nxt;
    logic          press_q;
    logic          rel_q;
    logic          lng_q;

    // Bring the asynchronous pin into the clk domain; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync      <= 1'b1;
        end else begin
            sync_meta <= key_in;
            sync      <= sync_meta;
        end
    end

    // The hold timer saturates so the long-press compare stays true once reached.
    always_comb begin
        hold_inc = (hold_cnt == LONG_LAST) ? hold_cnt : hold_cnt + 1'b1;
    end

    // Next-state and event decode for the debounce FSM.
    always_comb begin
        state_nxt     = state;
        deb_nxt       = deb_cnt;
        hold_nxt      = hold_cnt;
        long_done_nxt = long_done;
        level_nxt     = level;
        press_nxt     = 1'b0;
        rel_nxt       = 1'b0;
        lng_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (!sync) begin
                    state_nxt = S_PDEB;
                    deb_nxt   = '0;
                end
            end

            S_PDEB: begin
                if (sync) begin
                    state_nxt = S_IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = S_HELD;
                    level_nxt     = 1'b1;
                    press_nxt     = 1'b1;
                    hold_nxt      = '0;
                    long_done_nxt = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end

            S_HELD: begin
                hold_nxt = hold_inc;
                if ((hold_cnt == LONG_LAST) && !long_done) begin
                    lng_nxt       = 1'b1;
                    long_done_nxt = 1'b1;
                end
                if (sync) begin
                    state_nxt = S_RDEB;
                    deb_nxt   = '0;
                end
            end

            S_RDEB: begin
                // A release glitch must not restart the long timer, so it
                // keeps running here and long_done is left untouched.
                hold_nxt = hold_inc;
                if (!sync) begin
                    state_nxt = S_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = S_IDLE;
                    level_nxt = 1'b0;
                    rel_nxt   = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                level_nxt = 1'b0;
            end
        endcase
    end

    // FSM state, counters and level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            level     <= 1'b0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            hold_cnt  <= hold_nxt;
            long_done <= long_done_nxt;
            level     <= level_nxt;
        end
    end

    // Registered event pulses, each high for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            lng_q   <= 1'b0;
        end else begin
            press_q <= press_nxt;
            rel_q   <= rel_nxt;
            lng_q   <= lng_nxt;
        end
    end

    assign evt.level = level;
    assign evt.press = press_q;
    assign evt.rel   = rel_q;
    assign evt.lng   = lng_q;

endmodule

// File: rtl/key_debounce.sv
// Debouncer for the board's active-low push buttons. Each pin gets its own
// independent channel; events from different channels appear on their own
// bits in the same cycle with no prioritisation.
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_NUM     = 3,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [KEY_NUM-1:0] key_long
);

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_evt_t evt;

        key_debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .key_in (key_in[i]),
            .evt    (evt)
        );

        assign key_state[i]   = evt.level;
        assign key_press[i]   = evt.press;
        assign key_release[i] = evt.rel;
        assign key_long[i]    = evt.lng;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with short timing (DEB=16, LONG=64). A reference
// model built on run lengths of the synchronised pin level predicts every
// output each cycle; directed scenarios add absolute timing checks.
module tb_key_debounce;

    localparam int N    = 3;
    localparam int DEB  = 16;
    localparam int LONG = 64;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] key_in;
    logic [N-1:0] key_state;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;
    logic [N-1:0] key_long;

    int n_cmp;
    int n_bad;

    key_debounce #(
        .KEY_NUM     (N),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A press is accepted on the edge where the synchronised level has been
    // low for DEB+1 consecutive samples (1 to leave idle, DEB to count);
    // release likewise for high. The long event fires LONG edges after the
    // press, only on an edge where the previous sample was low (button not
    // in release debounce), once per hold.
    bit   m_p1 [N];
    bit   m_p2 [N];
    bit   m_prev [N];
    bit   m_held [N];
    bit   m_ldone [N];
    int   m_run0 [N];
    int   m_run1 [N];
    int   m_age [N];
    bit   m_s;
    logic [N-1:0] exp_state, exp_press, exp_rel, exp_long;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                m_p1[c] = 1'b1; m_p2[c] = 1'b1; m_prev[c] = 1'b1;
                m_held[c] = 1'b0; m_ldone[c] = 1'b0;
                m_run0[c] = 0; m_run1[c] = 0; m_age[c] = 0;
            end
            exp_state = '0; exp_press = '0; exp_rel = '0; exp_long = '0;
        end else begin
            exp_press = '0; exp_rel = '0; exp_long = '0;
            for (int c = 0; c < N; c++) begin
                m_s = m_p2[c];
                if (m_s) begin m_run1[c]++; m_run0[c] = 0; end
                else     begin m_run0[c]++; m_run1[c] = 0; end
                if (!m_held[c]) begin
                    if (!m_s && m_run0[c] == DEB + 1) begin
                        m_held[c] = 1'b1; exp_press[c] = 1'b1;
                        m_age[c] = 0; m_ldone[c] = 1'b0;
                    end
                end else begin
                    if (!m_prev[c] && m_age[c] == LONG - 1 && !m_ldone[c]) begin
                        exp_long[c] = 1'b1; m_ldone[c] = 1'b1;
                    end
                    if (m_age[c] < LONG - 1) m_age[c]++;
                    if (m_s && m_run1[c] == DEB + 1) begin
                        m_held[c] = 1'b0; exp_rel[c] = 1'b1;
                    end
                end
                exp_state[c] = m_held[c];
                m_prev[c] = m_s;
                m_p2[c] = m_p1[c];
                m_p1[c] = key_in[c];
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = '1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({key_state, key_press, key_release, key_long} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 000000000000",
                     {key_state, key_press, key_release, key_long});
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({key_state, key_press, key_release, key_long} !== 12'h000) begin
                n_bad++;
                $display("FAIL reset_idle k=%0d: got %b want all zero", k,
                         {key_state, key_press, key_release, key_long});
            end
        end
    endtask

    task automatic settle(input int cycles);
        key_in = '1;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({key_state, key_press, key_release, key_long} !==
                {exp_state, exp_press, exp_rel, exp_long}) begin
                n_bad++;
                $display("FAIL settle_model k=%0d: got %b want %b", k,
                         {key_state, key_press, key_release, key_long},
                         {exp_state, exp_press, exp_rel, exp_long});
            end
        end
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        key_in[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            n_cmp++;
            if (key_press !== ((k == 19) ? 3'b001 : 3'b000)) begin
                n_bad++;
                $display("FAIL clean_press k=%0d: got %b want %b", k, key_press,
                         (k == 19) ? 3'b001 : 3'b000);
            end
            n_cmp++;
            if (key_state !== ((k >= 19) ? 3'b001 : 3'b000)) begin
                n_bad++;
                $display("FAIL clean_state k=%0d: got %b", k, key_state);
            end
            n_cmp++;
            if ({key_release, key_long} !== 6'b0) begin
                n_bad++;
                $display("FAIL clean_other k=%0d: got %b want 000000", k, {key_release, key_long});
            end
        end
        key_in[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if (key_release !== ((k == 19) ? 3'b001 : 3'b000)) begin
                n_bad++;
                $display("FAIL clean_release k=%0d: got %b", k, key_release);
            end
        end
    endtask

    task automatic test_bounce();
        @(negedge clk);
        key_in[1] = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({key_state, key_press, key_release, key_long} !== 12'h000) begin
                n_bad++;
                $display("FAIL bounce k=%0d: got %b want all zero", k,
                         {key_state, key_press, key_release, key_long});
            end
            if (k < 60 && (k % 5) == 0) key_in[1] = ~key_in[1];
            else if (k >= 60)           key_in[1] = 1'b1;
        end
    endtask

    task automatic test_long_press();
        @(negedge clk);
        key_in[2] = 1'b0;
        for (int k = 1; k <= 240; k++) begin
            @(negedge clk);
            n_cmp++;
            if (key_press[2] !== (k == 19)) begin
                n_bad++;
                $display("FAIL long_press k=%0d: got %b", k, key_press[2]);
            end
            n_cmp++;
            if (key_long[2] !== (k == 19 + LONG)) begin
                n_bad++;
                $display("FAIL long_event k=%0d: got %b", k, key_long[2]);
            end
            n_cmp++;
            if (key_release[2] !== (k == 219)) begin
                n_bad++;
                $display("FAIL long_release k=%0d: got %b", k, key_release[2]);
            end
            if (k == 200) key_in[2] = 1'b1;
        end
    endtask

    task automatic test_release_glitch();
        @(negedge clk);
        key_in[0] = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            n_cmp++;
            if (key_state[0] !== (k >= 19)) begin
                n_bad++;
                $display("FAIL glitch_state k=%0d: got %b", k, key_state[0]);
            end
            n_cmp++;
            if (key_release[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_release k=%0d: got %b want 0", k, key_release[0]);
            end
            n_cmp++;
            if (key_long[0] !== (k == 19 + LONG)) begin
                n_bad++;
                $display("FAIL glitch_long k=%0d: got %b", k, key_long[0]);
            end
            if (k == 30) key_in[0] = 1'b1;
            if (k == 38) key_in[0] = 1'b0;
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        key_in = '0;
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            n_cmp++;
            if (key_press !== ((k == 19) ? 3'b111 : 3'b000)) begin
                n_bad++;
                $display("FAIL simul_press k=%0d: got %b", k, key_press);
            end
            n_cmp++;
            if (key_release !== ((k == 119) ? 3'b111 : 3'b000)) begin
                n_bad++;
                $display("FAIL simul_release k=%0d: got %b", k, key_release);
            end
            if (k == 100) key_in = '1;
        end
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        key_in[1] = 1'b0;
        repeat (30) @(negedge clk);
        n_cmp++;
        if (key_state[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_held: got %b want 1", key_state[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({key_state, key_press, key_release, key_long} !== 12'h000) begin
            n_bad++;
            $display("FAIL midrst_async: got %b want all zero",
                     {key_state, key_press, key_release, key_long});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if (key_press !== ((k == 19) ? 3'b010 : 3'b000)) begin
                n_bad++;
                $display("FAIL midrst_repress k=%0d: got %b", k, key_press);
            end
            n_cmp++;
            if (key_release !== 3'b000) begin
                n_bad++;
                $display("FAIL midrst_norelease k=%0d: got %b", k, key_release);
            end
        end
    endtask

    task automatic test_random(input int cycles);
        int rem [N];
        for (int c = 0; c < N; c++) rem[c] = $urandom_range(1, 30);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({key_state, key_press, key_release, key_long} !==
                {exp_state, exp_press, exp_rel, exp_long}) begin
                n_bad++;
                $display("FAIL random_model k=%0d: got %b want %b", k,
                         {key_state, key_press, key_release, key_long},
                         {exp_state, exp_press, exp_rel, exp_long});
            end
            for (int c = 0; c < N; c++) begin
                rem[c]--;
                if (rem[c] == 0) begin
                    key_in[c] = ~key_in[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 150)
                                                         : $urandom_range(1, 30);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        key_in = '1;
        test_reset();
        test_clean_press();
        settle(30);
        test_bounce();
        settle(30);
        test_long_press();
        settle(30);
        test_release_glitch();
        key_in[0] = 1'b1;
        settle(40);
        test_simultaneous();
        settle(30);
        test_reset_mid_hold();
        settle(40);
        test_random(4000);
        settle(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
